// File: rtl/io_bank_if.sv
// Bus interface between the load/store unit and io_bank.
//   IOA  [5:0]   address: [5:4] space, [3:0] index
//   IOD  [DW-1:0] write data
//   IOM  [1:0]   write mode (00 write, 01 set, 10 clear, 11 toggle)
//   IOE          write strobe
//   IOR          read strobe
//   IOQ  [DW-1:0] registered read data
//   IOQV         read data valid, one-cycle pulse
interface io_bank_if #(
  parameter int unsigned DW = 32
) ();
  logic [5:0]    IOA;
  logic [DW-1:0] IOD;
  logic [1:0]    IOM;
  logic          IOE;
  logic          IOR;
  logic [DW-1:0] IOQ;
  logic          IOQV;

  modport master (
    output IOA, IOD, IOM, IOE, IOR,
    input  IOQ, IOQV
  );

  modport slave (
    input  IOA, IOD, IOM, IOE, IOR,
    output IOQ, IOQV
  );
endinterface

// File: rtl/io_bank.sv
// Memory-mapped I/O register bank.
// Output registers with write/set/clear/toggle, per-channel two-flop synchroniser plus debounce,
// sticky rising-edge event flags (write-1-to-clear), per-channel interrupt enables and a
// registered interrupt request. Read data is registered and qualified by a one-cycle valid.
//   CLK      clock, all state changes on rising edge
//   RST      asynchronous active-high reset
//   bus      io_bank_if slave: address/data/mode/strobes in, read data/valid out
//   PIN_IN   raw asynchronous inputs, channel i at [i*IW +: IW]
//   PIN_OUT  output registers, register i at [i*DW +: DW]
//   IRQ      registered interrupt request
module io_bank #(
  parameter int unsigned      DW      = 32,
  parameter int unsigned      NO      = 10,
  parameter int unsigned      NI      = 8,
  parameter int unsigned      IW      = 8,
  parameter int unsigned      CW      = 16,
  parameter logic [CW-1:0]    DB_INIT = CW'(1000)
) (
  input  logic             CLK,
  input  logic             RST,
  io_bank_if.slave         bus,
  input  logic [NI*IW-1:0] PIN_IN,
  output logic [NO*DW-1:0] PIN_OUT,
  output logic             IRQ
);

  localparam logic [1:0] SpOut = 2'b00;
  localparam logic [1:0] SpLvl = 2'b01;
  localparam logic [1:0] SpEvt = 2'b10;
  localparam logic [1:0] SpCtl = 2'b11;

  // Output registers
  logic [DW-1:0] out_q [NO];
  logic [DW-1:0] out_d [NO];

  // Input path
  logic [IW-1:0] s1_q    [NI];
  logic [IW-1:0] s2_q    [NI];
  logic [IW-1:0] lvl_q   [NI];
  logic [IW-1:0] lvl_d   [NI];
  logic [CW-1:0] cnt_q   [NI];
  logic [CW-1:0] cnt_d   [NI];
  logic [IW-1:0] evt_q   [NI];
  logic [IW-1:0] evt_d   [NI];
  logic [IW-1:0] evt_set [NI];
  logic [IW-1:0] evt_clr [NI];

  // Control
  logic [CW-1:0] dbt_q, dbt_d;
  logic [NI-1:0] ien_q, ien_d;

  // Read port and interrupt
  logic [DW-1:0] rdata;
  logic [DW-1:0] ioq_q, ioq_d;
  logic          ioqv_q;
  logic          irq_q, irq_d;

  logic [3:0] idx;
  logic [1:0] space;

  assign idx   = bus.IOA[3:0];
  assign space = bus.IOA[5:4];

  // Debounce and event flags
  always_comb begin
    for (int i = 0; i < int'(NI); i++) begin
      lvl_d[i]   = lvl_q[i];
      cnt_d[i]   = cnt_q[i];
      evt_set[i] = '0;
      evt_clr[i] = '0;
      if (s2_q[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] < dbt_q) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else begin
        // Counter does not restart when S2 moves between two non-LVL values.
        lvl_d[i]   = s2_q[i];
        cnt_d[i]   = '0;
        evt_set[i] = s2_q[i] & ~lvl_q[i];
      end
      if (bus.IOE && space == SpEvt && idx == 4'(i)) begin
        evt_clr[i] = bus.IOD[IW-1:0];
      end
      // A new edge beats a same-cycle clear.
      evt_d[i] = (evt_q[i] & ~evt_clr[i]) | evt_set[i];
    end
  end

  // Output register and control writes
  always_comb begin
    for (int i = 0; i < int'(NO); i++) begin
      out_d[i] = out_q[i];
      if (bus.IOE && space == SpOut && idx == 4'(i)) begin
        case (bus.IOM)
          2'b00:   out_d[i] = bus.IOD;
          2'b01:   out_d[i] = out_q[i] | bus.IOD;
          2'b10:   out_d[i] = out_q[i] & ~bus.IOD;
          default: out_d[i] = out_q[i] ^ bus.IOD;
        endcase
      end
    end
    dbt_d = dbt_q;
    ien_d = ien_q;
    if (bus.IOE && space == SpCtl) begin
      if (idx == 4'd0) dbt_d = bus.IOD[CW-1:0];
      if (idx == 4'd1) ien_d = bus.IOD[NI-1:0];
    end
  end

  // Read mux over pre-edge state; unmapped indices read as zero.
  always_comb begin
    rdata = '0;
    case (space)
      SpOut: begin
        for (int i = 0; i < int'(NO); i++) begin
          if (idx == 4'(i)) rdata = out_q[i];
        end
      end
      SpLvl: begin
        for (int i = 0; i < int'(NI); i++) begin
          if (idx == 4'(i)) rdata[IW-1:0] = lvl_q[i];
        end
      end
      SpEvt: begin
        for (int i = 0; i < int'(NI); i++) begin
          if (idx == 4'(i)) rdata[IW-1:0] = evt_q[i];
        end
      end
      default: begin
        if (idx == 4'd0) begin
          rdata[CW-1:0] = dbt_q;
        end else if (idx == 4'd1) begin
          rdata[NI-1:0] = ien_q;
        end
      end
    endcase
    ioq_d = bus.IOR ? rdata : ioq_q;
  end

  // IRQ lags the event flags by one edge.
  always_comb begin
    irq_d = 1'b0;
    for (int i = 0; i < int'(NI); i++) begin
      irq_d = irq_d | (ien_q[i] & (|evt_q[i]));
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_q  <= '{default: '0};
      s1_q   <= '{default: '0};
      s2_q   <= '{default: '0};
      lvl_q  <= '{default: '0};
      cnt_q  <= '{default: '0};
      evt_q  <= '{default: '0};
      dbt_q  <= DB_INIT;
      ien_q  <= '0;
      ioq_q  <= '0;
      ioqv_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NI); i++) begin
        s1_q[i] <= PIN_IN[i*IW +: IW];
      end
      s2_q   <= s1_q;
      lvl_q  <= lvl_d;
      cnt_q  <= cnt_d;
      evt_q  <= evt_d;
      out_q  <= out_d;
      dbt_q  <= dbt_d;
      ien_q  <= ien_d;
      ioq_q  <= ioq_d;
      ioqv_q <= bus.IOR;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    PIN_OUT = '0;
    for (int i = 0; i < int'(NO); i++) begin
      PIN_OUT[i*DW +: DW] = out_q[i];
    end
  end

  assign bus.IOQ  = ioq_q;
  assign bus.IOQV = ioqv_q;
  assign IRQ      = irq_q;

endmodule
